spi_burst_reader: RTL

Parametrised SPI mode-0 master that periodically or on demand issues a two-byte command (instruction + start address) and reads a burst of NUM_BYTES bytes from a sensor register file (e.g. ADXL362 data registers). It generates SCLK itself, enforces CS setup, hold and gap times, and presents each completed burst as a packed word with a one-cycle valid strobe. It sits between the board SPI pins and the sensor-consuming logic such as the rng.

---
 rtl/spi_burst_reader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_reader.sv
// spi_burst_reader: SPI mode-0 master that sends a two-byte command
// (instruction + start address) and then reads a burst of NUM_BYTES bytes.
// A burst starts on a manual start pulse or on an internal periodic tick.
// Each finished burst appears on data with a one-cycle valid strobe.
//
// Optional build macro: SPI_BURST_READER_OVERRUN_EN
//   When defined, the module adds a clr_overrun input and a sticky overrun
//   output. overrun flags a trigger that was dropped because a burst was
//   already queued.
module spi_burst_reader #(
    parameter int          CLK_DIV       = 4,
    parameter int          NUM_BYTES     = 4,
    parameter logic [7:0]  CMD_BYTE      = 8'h0B,
    parameter logic [7:0]  ADDR_BYTE     = 8'h0E,
    parameter int          SAMPLE_PERIOD = 650000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     miso,
`ifdef SPI_BURST_READER_OVERRUN_EN
    input  logic                     clr_overrun,
    output logic                     overrun,
`endif
    output logic                     sclk,
    output logic                     mosi,
    output logic                     csn,
    output logic                     busy,
    output logic                     valid,
    output logic [8*NUM_BYTES-1:0]   data
);

    localparam int NBITS = 16 + 8 * NUM_BYTES;
    localparam int DW    = 8 * NUM_BYTES;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NBITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [BIT_W-1:0]   bit_reg;
    logic [15:0]        tx_reg;
    logic [7:0]         byte_reg;
    logic [DW-1:0]      rx_reg;
    logic               pending_reg;
    logic               trig_reg;
    logic               tick;
    logic               div_last;
    logic [7:0]         byte_next;

    assign div_last  = (div_reg == DIV_W'(CLK_DIV - 1));
    assign byte_next = {byte_reg[6:0], miso};

    // Free-running sample timer; frozen while en is low, absent when the
    // period is zero.
    generate
        if (SAMPLE_PERIOD > 0) begin : g_timer
            localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
            logic [TW-1:0] timer_reg;

            // Count 0..SAMPLE_PERIOD-1 while enabled, wrapping to zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer_reg <= '0;
                end else if (en) begin
                    if (timer_reg == TW'(SAMPLE_PERIOD - 1))
                        timer_reg <= '0;
                    else
                        timer_reg <= timer_reg + 1'b1;
                end
            end

            assign tick = en && (timer_reg == TW'(SAMPLE_PERIOD - 1));
        end else begin : g_no_timer
            assign tick = 1'b0;
        end
    endgenerate

    // Register the combined trigger so a coincident start and tick count once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trig_reg <= 1'b0;
        else
            trig_reg <= start | tick;
    end

    // Burst sequencer: CS setup, bit shifting, CS hold and inter-burst gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            div_reg     <= '0;
            bit_reg     <= '0;
            tx_reg      <= '0;
            byte_reg    <= '0;
            rx_reg      <= '0;
            pending_reg <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            csn         <= 1'b1;
            busy        <= 1'b0;
            valid       <= 1'b0;
            data        <= '0;
        end else begin
            valid <= 1'b0;

            // Any trigger arriving while a burst is in flight is queued;
            // a second one is simply lost.
            if (trig_reg && (state_reg != S_IDLE))
                pending_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (trig_reg) begin
                        state_reg <= S_SETUP;
                        csn       <= 1'b0;
                        busy      <= 1'b1;
                        div_reg   <= '0;
                        tx_reg    <= {CMD_BYTE, ADDR_BYTE};
                    end
                end

                S_SETUP: begin
                    if (div_last) begin
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= S_SHIFT;
                        // First command bit is presented at the start of bit 0.
                        mosi      <= tx_reg[15];
                        tx_reg    <= {tx_reg[14:0], 1'b0};
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (div_last) begin
                        div_reg <= '0;
                        if (!sclk) begin
                            // Rising SCLK edge: capture MISO for the read phase.
                            sclk <= 1'b1;
                            if (bit_reg >= BIT_W'(16)) begin
                                byte_reg <= byte_next;
                                if (bit_reg[2:0] == 3'd7)
                                    rx_reg <= (rx_reg >> 8) | (DW'(byte_next) << (DW - 8));
                            end
                        end else begin
                            // Falling SCLK edge: end of bit, present the next one.
                            sclk <= 1'b0;
                            if (bit_reg == BIT_W'(NBITS - 1)) begin
                                state_reg <= S_HOLD;
                                mosi      <= 1'b0;
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                                mosi    <= tx_reg[15];
                                tx_reg  <= {tx_reg[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (div_last) begin
                        div_reg   <= '0;
                        csn       <= 1'b1;
                        data      <= rx_reg;
                        valid     <= 1'b1;
                        state_reg <= S_GAP;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                S_GAP: begin
                    if (div_last) begin
                        div_reg <= '0;
                        if (pending_reg || trig_reg) begin
                            // Launch the queued burst straight away.
                            pending_reg <= 1'b0;
                            state_reg   <= S_SETUP;
                            csn         <= 1'b0;
                            tx_reg      <= {CMD_BYTE, ADDR_BYTE};
                        end else begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_BURST_READER_OVERRUN_EN
    logic overrun_set;
    assign overrun_set = trig_reg && pending_reg && (state_reg != S_IDLE);

    // Sticky dropped-trigger flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (overrun_set)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end
`endif

endmodule
